// File: rtl/mem_stage_sequencer_pkg.sv
// LC-3b shared types: opcodes, data word, byte enables and memory-op classification helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_byte_en;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) ||
           (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_byte_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

  // Only STR/STB write on their first access; STI reads its pointer first.
  function automatic logic is_direct_store(input logic [3:0] op);
    return (op == OP_STR) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/mem_stage_sequencer_load_align.sv
// Load alignment: picks the addressed byte for LDB and extends it, passes words through.
module lc3b_load_align
  import lc3b_types::*;
(
  input  logic [15:0] rdata,
  input  logic        addr0,
  input  logic        is_byte,
  input  logic        sext,
  output logic [15:0] load_data
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = addr0 ? rdata[15:8] : rdata[7:0];
    if (!is_byte)
      load_data = rdata;
    else if (sext)
      load_data = {{8{w_byte[7]}}, w_byte};
    else
      load_data = {8'h00, w_byte};
  end

endmodule

// File: rtl/mem_stage_sequencer.sv
// LC-3b MEM-stage data-memory sequencer (direct and indirect loads/stores).
// Optional MISALIGN_TRAP_EN: misaligned word accesses trap with misalign_fault instead of forcing even.
module mem_stage_sequencer
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter bit          LDB_SEXT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       store_data,
  input  logic              dmem_resp,
  input  logic [15:0]       dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [1:0]        dmem_byte_en,
  output logic [15:0]       dmem_wdata,
  output logic [15:0]       load_data,
  output logic              done,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_fault,
`endif
  output logic              stall
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_opcode;
  logic              r_addr0;
  lc3b_word          r_store_data;
  logic              r_dmem_read;
  logic              r_dmem_write;
  logic [ADDR_W-1:0] r_dmem_address;
  lc3b_byte_en       r_dmem_byte_en;
  lc3b_word          r_dmem_wdata;
  lc3b_word          r_load_data;
  logic              r_done;
  logic              r_stall;

  logic              w_accept;
  logic              w_byte_in;
  logic [ADDR_W-1:0] w_req_addr;
  lc3b_byte_en       w_req_be;
  lc3b_word          w_req_wdata;
  logic [ADDR_W-1:0] w_ptr_addr;
  lc3b_word          w_aligned;
  logic              w_trap_word;
  logic              w_trap_ptr;

  assign w_accept    = (r_state == S_IDLE) && valid && is_mem_op(opcode);
  assign w_byte_in   = is_byte_op(opcode);
  assign w_req_addr  = w_byte_in ? addr : {addr[ADDR_W-1:1], 1'b0};
  assign w_req_be    = w_byte_in ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign w_req_wdata = w_byte_in ? {store_data[7:0], store_data[7:0]} : store_data;
  assign w_ptr_addr  = ADDR_W'({dmem_rdata[15:1], 1'b0});

`ifdef MISALIGN_TRAP_EN
  assign w_trap_word = !w_byte_in && addr[0];
  assign w_trap_ptr  = dmem_rdata[0];
`else
  assign w_trap_word = 1'b0;
  assign w_trap_ptr  = 1'b0;
`endif

  lc3b_load_align u_align (
    .rdata     (dmem_rdata),
    .addr0     (r_addr0),
    .is_byte   (is_byte_op(r_opcode)),
    .sext      (LDB_SEXT),
    .load_data (w_aligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_opcode       <= '0;
      r_addr0        <= 1'b0;
      r_store_data   <= '0;
      r_dmem_read    <= 1'b0;
      r_dmem_write   <= 1'b0;
      r_dmem_address <= '0;
      r_dmem_byte_en <= '0;
      r_dmem_wdata   <= '0;
      r_load_data    <= '0;
      r_done         <= 1'b0;
      r_stall        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opcode     <= opcode;
            r_addr0      <= addr[0];
            r_store_data <= store_data;
            if (w_trap_word) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state        <= S_FIRST;
              r_stall        <= 1'b1;
              r_dmem_read    <= !is_direct_store(opcode);
              r_dmem_write   <= is_direct_store(opcode);
              r_dmem_address <= w_req_addr;
              r_dmem_byte_en <= w_req_be;
              r_dmem_wdata   <= w_req_wdata;
            end
          end
        end
        S_FIRST: begin
          if (dmem_resp) begin
            if (is_indirect(r_opcode) && !w_trap_ptr) begin
              // Pointer arrives here; the second access is issued back-to-back.
              r_state        <= S_SECOND;
              r_dmem_address <= w_ptr_addr;
              r_dmem_byte_en <= 2'b11;
              r_dmem_read    <= (r_opcode == OP_LDI);
              r_dmem_write   <= (r_opcode == OP_STI);
              r_dmem_wdata   <= r_store_data;
            end else begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_stall      <= 1'b0;
              r_dmem_read  <= 1'b0;
              r_dmem_write <= 1'b0;
              if (!is_direct_store(r_opcode) && !is_indirect(r_opcode))
                r_load_data <= w_aligned;
            end
          end
        end
        S_SECOND: begin
          if (dmem_resp) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_stall      <= 1'b0;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            if (r_opcode == OP_LDI)
              r_load_data <= w_aligned;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_fault <= 1'b0;
    else
      r_fault <= (w_accept && w_trap_word) ||
                 ((r_state == S_FIRST) && dmem_resp && is_indirect(r_opcode) && w_trap_ptr);
  end

  assign misalign_fault = r_fault;
`endif

  assign dmem_read    = r_dmem_read;
  assign dmem_write   = r_dmem_write;
  assign dmem_address = r_dmem_address;
  assign dmem_byte_en = r_dmem_byte_en;
  assign dmem_wdata   = r_dmem_wdata;
  assign load_data    = r_load_data;
  assign stall        = r_stall;
  // Non-memory ops complete combinationally from IDLE without touching the FSM.
  assign done = r_done || (reset_n && (r_state == S_IDLE) && valid && !is_mem_op(opcode));

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Scoreboard bench for mem_stage_sequencer: memory responder checks requests, driver checks results.
module tb_mem_stage_sequencer;
  import lc3b_types::*;

  localparam bit SEXT = 1'b1;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int unsigned waits;
  } req_t;

  typedef struct {
    logic [15:0] ld;
    logic        fault;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic [3:0]  opcode;
  logic [15:0] addr;
  logic [15:0] store_data;
  logic        dmem_resp = 1'b0;
  logic [15:0] dmem_rdata = 16'h0000;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address;
  logic [1:0]  dmem_byte_en;
  logic [15:0] dmem_wdata;
  logic [15:0] load_data;
  logic        done, stall;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  logic        stray_resp = 1'b0;
  req_t        q_req[$];
  res_t        q_res[$];
  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  mem_stage_sequencer #(.ADDR_W(16), .LDB_SEXT(SEXT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid        (valid),
    .opcode       (opcode),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_byte_en (dmem_byte_en),
    .dmem_wdata   (dmem_wdata),
    .load_data    (load_data),
    .done         (done),
`ifdef MISALIGN_TRAP_EN
    .misalign_fault (misalign_fault),
`endif
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_req(input logic [15:0] a, input logic wr, input logic [1:0] be,
                          input logic [15:0] wd, input logic [15:0] rd, input int unsigned w);
    req_t r;
    r.addr = a; r.wr = wr; r.be = be; r.wdata = wd; r.rdata = rd; r.waits = w;
    q_req.push_back(r);
  endtask

  // Memory model: checks each new request against the scoreboard, answers after its wait count.
  req_t        cur;
  logic        seen = 1'b0;
  int unsigned wcnt = 0;

  always @(negedge clk) begin
    dmem_resp = 1'b0;
    if (!reset_n) begin
      seen = 1'b0;
    end else if (dmem_read || dmem_write) begin
      check("rw_excl", {31'd0, dmem_read & dmem_write}, 32'd0);
      if (!seen) begin
        if (q_req.size() == 0) begin
          check("req_unexpected", dmem_address, 32'hFFFF_0000);
        end else begin
          cur  = q_req.pop_front();
          seen = 1'b1;
          wcnt = cur.waits;
          check("req_addr", dmem_address, cur.addr);
          check("req_write", dmem_write, cur.wr);
          check("req_read", dmem_read, !cur.wr);
          check("req_be", dmem_byte_en, cur.be);
          if (cur.wr) check("req_wdata", dmem_wdata, cur.wdata);
        end
      end
      if (seen) begin
        if (wcnt == 0) begin
          dmem_resp  = 1'b1;
          dmem_rdata = cur.rdata;
          seen       = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end else begin
      seen = 1'b0;
      if (stray_resp) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hA5A5;
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                       input int unsigned exp_lat, input logic [15:0] exp_ld,
                       input logic exp_fault, input logic stray);
    int unsigned n;
    logic        got;
    res_t        r;
    res_t        e;
    @(posedge clk); #1;
    valid = 1'b1; opcode = op; addr = a; store_data = sd; stray_resp = stray;
    e.ld = exp_ld; e.fault = exp_fault;
    q_res.push_back(e);
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        check("stall", {31'd0, stall}, {31'd0, n != 0});
        if (n == 0) begin #1; stray_resp = 1'b0; end
        if (n == 1) begin
          valid = 1'b1; opcode = OP_LDR; addr = 16'hFFFF; store_data = 16'hDEAD;
        end
        n++;
      end
    end
    r = q_res.pop_front();
    if (!got) begin
      check("done_timeout", {31'd0, got}, 32'd1);
    end else begin
      check("latency", n, exp_lat);
      check("stall_at_done", {31'd0, stall}, 32'd0);
      check("load_data", load_data, r.ld);
`ifdef MISALIGN_TRAP_EN
      check("fault", {31'd0, misalign_fault}, {31'd0, r.fault});
`endif
    end
    @(posedge clk); #1;
    valid = 1'b0; stray_resp = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"}, {31'd0, dmem_read}, 32'd0);
    check({tag, "_wr"}, {31'd0, dmem_write}, 32'd0);
    check({tag, "_addr"}, dmem_address, 32'd0);
    check({tag, "_be"}, {30'd0, dmem_byte_en}, 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_ld"}, load_data, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check({tag, "_fault"}, {31'd0, misalign_fault}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; valid = 1'b0; opcode = 4'h0; addr = 16'h0; store_data = 16'h0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    push_req(16'h3000, 1'b0, 2'b11, 16'h0, 16'hBEEF, 2);
    do_op(OP_LDR, 16'h3000, 16'h0, 4, 16'hBEEF, 1'b0, 1'b0);

    push_req(16'h3001, 1'b0, 2'b10, 16'h0, 16'h80AA, 0);
    do_op(OP_LDB, 16'h3001, 16'h0, 2, SEXT ? 16'hFF80 : 16'h0080, 1'b0, 1'b0);

    push_req(16'h3000, 1'b0, 2'b01, 16'h0, 16'h80AA, 1);
    do_op(OP_LDB, 16'h3000, 16'h0, 3, SEXT ? 16'hFFAA : 16'h00AA, 1'b0, 1'b1);

    push_req(16'h4000, 1'b1, 2'b01, 16'h3434, 16'h0, 0);
    do_op(OP_STB, 16'h4000, 16'h1234, 2, SEXT ? 16'hFFAA : 16'h00AA, 1'b0, 1'b0);

    push_req(16'h4001, 1'b1, 2'b10, 16'hF0F0, 16'h0, 0);
    do_op(OP_STB, 16'h4001, 16'h12F0, 2, SEXT ? 16'hFFAA : 16'h00AA, 1'b0, 1'b0);

    push_req(16'h4002, 1'b1, 2'b11, 16'hCAFE, 16'h0, 1);
    do_op(OP_STR, 16'h4002, 16'hCAFE, 3, SEXT ? 16'hFFAA : 16'h00AA, 1'b0, 1'b0);

    push_req(16'h5000, 1'b0, 2'b11, 16'h0, 16'h6002, 0);
    push_req(16'h6002, 1'b0, 2'b11, 16'h0, 16'h00C3, 0);
    do_op(OP_LDI, 16'h5000, 16'h0, 3, 16'h00C3, 1'b0, 1'b0);

`ifdef MISALIGN_TRAP_EN
    push_req(16'h5100, 1'b0, 2'b11, 16'h0, 16'h6201, 0);
    do_op(OP_STI, 16'h5100, 16'hABCD, 2, 16'h00C3, 1'b1, 1'b0);
`else
    push_req(16'h5100, 1'b0, 2'b11, 16'h0, 16'h6201, 0);
    push_req(16'h6200, 1'b1, 2'b11, 16'hABCD, 16'h0, 1);
    do_op(OP_STI, 16'h5100, 16'hABCD, 4, 16'h00C3, 1'b0, 1'b0);
`endif

    do_op(OP_ADD, 16'h1111, 16'h2222, 0, 16'h00C3, 1'b0, 1'b1);

`ifdef MISALIGN_TRAP_EN
    do_op(OP_LDR, 16'h3001, 16'h0, 1, 16'h00C3, 1'b1, 1'b0);
`else
    push_req(16'h3000, 1'b0, 2'b11, 16'h0, 16'h2468, 0);
    do_op(OP_LDR, 16'h3001, 16'h0, 2, 16'h2468, 1'b0, 1'b0);
`endif

    // STI aborted by reset while its second (write) access is outstanding.
    push_req(16'h7000, 1'b0, 2'b11, 16'h0, 16'h7100, 0);
    push_req(16'h7100, 1'b1, 2'b11, 16'h5555, 16'h0, 5);
    @(posedge clk); #1;
    valid = 1'b1; opcode = OP_STI; addr = 16'h7000; store_data = 16'h5555;
    @(posedge clk); #1 valid = 1'b0;
    repeat (2) @(negedge clk);
    check("sti_second_wr", {31'd0, dmem_write}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1 reset_n = 1'b1;
    q_req.delete();

    push_req(16'h0010, 1'b0, 2'b11, 16'h0, 16'h1357, 1);
    do_op(OP_LDR, 16'h0010, 16'h0, 3, 16'h1357, 1'b0, 1'b0);

    push_req(16'h5200, 1'b0, 2'b11, 16'h0, 16'h1234, 1);
    push_req(16'h1234, 1'b0, 2'b11, 16'h0, 16'h7E01, 2);
    do_op(OP_LDI, 16'h5200, 16'h0, 6, 16'h7E01, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("req_left", q_req.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
